// File: rtl/mux_tdm_if.sv
// Bus bundle for mux_tdm: control/data inputs and the registered sample outputs.
// The master drives the channel words and controls; the slave returns the selected sample.
interface mux_tdm_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SEL_W = 2
);
   logic                   en;
   logic                   mode;
   logic [SEL_W-1:0]       sel_in;
   logic [NCH*WIDTH-1:0]   din;
   logic [WIDTH-1:0]       dout;
   logic [SEL_W-1:0]       sel_out;
   logic                   valid;
   logic                   wrap;
   logic                   err;

   modport master (
      output en, mode, sel_in, din,
      input  dout, sel_out, valid, wrap, err
   );

   modport slave (
      input  en, mode, sel_in, din,
      output dout, sel_out, valid, wrap, err
   );
endinterface

// File: rtl/mux_tdm.sv
// Registered NCH:1 word multiplexer with manual select and round-robin scan modes.
// Optional break-before-make blanking on channel change when MUX_BLANK_EN is defined.
module mux_tdm #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SEL_W = 2,
   parameter int DWELL = 4
) (
   input logic     clk,
   input logic     rst,
   mux_tdm_if.slave bus
);
   localparam int                 CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SEL_W:0]     NCH_W    = (SEL_W+1)'(NCH);
   localparam logic [SEL_W-1:0]   LAST_CH  = SEL_W'(NCH - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);

   logic [SEL_W-1:0] ch_q, ch_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [SEL_W-1:0] sel_out_q, sel_out_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic [SEL_W-1:0] src_s;

   function automatic logic [WIDTH-1:0] pick_word(input logic [NCH*WIDTH-1:0] d,
                                                  input logic [SEL_W-1:0]     idx);
      logic [WIDTH-1:0] w;
      w = {WIDTH{1'b0}};
      for (int k = 0; k < NCH; k++) begin
         if (idx == SEL_W'(k)) begin
            w = d[k*WIDTH +: WIDTH];
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

   // Next-state and next-output selection for both modes.
   always_comb begin
      ch_d      = ch_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      sel_out_d = sel_out_q;
      valid_d   = 1'b0;
      wrap_d    = 1'b0;
      err_d     = 1'b0;
      src_s     = ch_q;
      if (bus.en) begin
         if (!bus.mode) begin
            cnt_d = {CNT_W{1'b0}};
            if ({1'b0, bus.sel_in} < NCH_W) begin
               ch_d  = bus.sel_in;
               src_s = bus.sel_in;
            end else begin
               err_d = 1'b1;
               src_s = ch_q;
            end
         end else begin
            src_s = ch_q;
            if (cnt_q == CNT_LAST) begin
               cnt_d  = {CNT_W{1'b0}};
               ch_d   = (ch_q == LAST_CH) ? {SEL_W{1'b0}} : ch_q + SEL_W'(1);
               wrap_d = (ch_q == LAST_CH);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         sel_out_d = src_s;
`ifdef MUX_BLANK_EN
         // A sample from a channel other than the last one shown is blanked once.
         if (src_s != sel_out_q) begin
            dout_d  = {WIDTH{1'b0}};
            valid_d = 1'b0;
         end else begin
            dout_d  = pick_word(bus.din, src_s);
            valid_d = 1'b1;
         end
`else
         dout_d  = pick_word(bus.din, src_s);
         valid_d = 1'b1;
`endif
      end else begin
         valid_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_q      <= {SEL_W{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         dout_q    <= {WIDTH{1'b0}};
         sel_out_q <= {SEL_W{1'b0}};
         valid_q   <= 1'b0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ch_q      <= ch_d;
         cnt_q     <= cnt_d;
         dout_q    <= dout_d;
         sel_out_q <= sel_out_d;
         valid_q   <= valid_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
      end
   end

   assign bus.dout    = dout_q;
   assign bus.sel_out = sel_out_q;
   assign bus.valid   = valid_q;
   assign bus.wrap    = wrap_q;
   assign bus.err     = err_q;
endmodule

// File: tb/tb_mux_tdm.sv
// Directed bench for mux_tdm: a vector table on a 4-channel instance plus
// hand-written sequences on a 3-channel instance for invalid select and wrap.
module tb_mux_tdm;
   logic        clk;
   logic        rst;
   logic        en;
   logic        mode;
   logic [1:0]  sel;
   logic [31:0] din;

   int n_checks;
   int n_errors;

   mux_tdm_if #(.WIDTH(8), .NCH(4), .SEL_W(2)) if4 ();
   mux_tdm_if #(.WIDTH(8), .NCH(3), .SEL_W(2)) if3 ();

   assign if4.en = en;
   assign if4.mode = mode;
   assign if4.sel_in = sel;
   assign if4.din = din;
   assign if3.en = en;
   assign if3.mode = mode;
   assign if3.sel_in = sel;
   assign if3.din = din[23:0];

   mux_tdm #(.WIDTH(8), .NCH(4), .SEL_W(2), .DWELL(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
   mux_tdm #(.WIDTH(8), .NCH(3), .SEL_W(2), .DWELL(4)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, en, mode;
      logic [1:0]  sel;
      logic [31:0] din;
      logic [7:0]  x_dout;
      logic [1:0]  x_sel;
      logic        x_valid, x_wrap, x_err;
   } vec_t;

   vec_t vecs[$];

   localparam logic [31:0] D0 = 32'hDDCCBBAA;
   localparam logic [31:0] D1 = 32'h44332211;

   task automatic add(input logic r, e, m, input logic [1:0] s, input logic [31:0] d,
                      input logic [7:0] xd, input logic [1:0] xs,
                      input logic xv, xw, xe);
      vec_t v;
      v = '{rst: r, en: e, mode: m, sel: s, din: d, x_dout: xd, x_sel: xs,
            x_valid: xv, x_wrap: xw, x_err: xe};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
      end
   endtask

   task automatic drive(input logic r, e, m, input logic [1:0] s, input logic [31:0] d);
      @(negedge clk);
      rst = r; en = e; mode = m; sel = s; din = d;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] byte_of(input logic [31:0] d, input int c);
      logic [31:0] t;
      t = d >> (8 * c);
      return t[7:0];
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0; din = 32'd0;

      // reset held three cycles with scan requested
      for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, 2'd0, D0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
      // full scan rotation plus first sample of the next rotation
      for (int k = 0; k < 17; k++)
         add(1'b0, 1'b1, 1'b1, 2'd0, D0, byte_of(D0, (k / 4) % 4), 2'((k / 4) % 4),
             1'b1, (k == 15), 1'b0);
      // manual selects 2, 0, 3
      add(1'b0, 1'b1, 1'b0, 2'd2, D0, 8'hCC, 2'd2, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 2'd0, D0, 8'hAA, 2'd0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 2'd3, D0, 8'hDD, 2'd3, 1'b1, 1'b0, 1'b0);
      // park on channel 1, then scan two samples to reach cnt=2
      add(1'b0, 1'b1, 1'b0, 2'd1, D0, 8'hBB, 2'd1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 2'd3, D0, 8'hBB, 2'd1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 2'd3, D0, 8'hBB, 2'd1, 1'b1, 1'b0, 1'b0);
      // freeze for five cycles
      for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b1, 2'd0, D0, 8'hBB, 2'd1, 1'b0, 1'b0, 1'b0);
      // channel 1 finishes its dwell, then channel 2
      add(1'b0, 1'b1, 1'b1, 2'd0, D0, 8'hBB, 2'd1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 2'd0, D0, 8'hBB, 2'd1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 2'd0, D0, 8'hCC, 2'd2, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 2'd0, D0, 8'hCC, 2'd2, 1'b1, 1'b0, 1'b0);
      // din change mid-dwell is tracked
      add(1'b0, 1'b1, 1'b1, 2'd0, D1, 8'h33, 2'd2, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 2'd0, D1, 8'h33, 2'd2, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 2'd0, D1, 8'h44, 2'd3, 1'b1, 1'b0, 1'b0);
      // reset mid-scan restarts at channel 0 with a full dwell
      add(1'b1, 1'b1, 1'b1, 2'd0, D0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, 2'd0, D0, 8'hAA, 2'd0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 2'd0, D0, 8'hBB, 2'd1, 1'b1, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].sel, vecs[i].din);
         check("dout",    i, 32'(if4.dout),    32'(vecs[i].x_dout));
         check("sel_out", i, 32'(if4.sel_out), 32'(vecs[i].x_sel));
         check("valid",   i, 32'(if4.valid),   32'(vecs[i].x_valid));
         check("wrap",    i, 32'(if4.wrap),    32'(vecs[i].x_wrap));
         check("err",     i, 32'(if4.err),     32'(vecs[i].x_err));
      end

      // 3-channel instance: invalid select holds the current channel for one err pulse
      drive(1'b1, 1'b1, 1'b0, 2'd0, D0);
      drive(1'b0, 1'b1, 1'b0, 2'd1, D0);
      check("n3_sel1_dout", 0, 32'(if3.dout), 32'h0000_00BB);
      check("n3_sel1_err",  0, 32'(if3.err),  32'd0);
      drive(1'b0, 1'b1, 1'b0, 2'd3, D0);
      check("n3_bad_dout",  1, 32'(if3.dout),    32'h0000_00BB);
      check("n3_bad_sel",   1, 32'(if3.sel_out), 32'd1);
      check("n3_bad_valid", 1, 32'(if3.valid),   32'd1);
      check("n3_bad_err",   1, 32'(if3.err),     32'd1);
      drive(1'b0, 1'b1, 1'b0, 2'd0, D0);
      check("n3_sel0_dout", 2, 32'(if3.dout), 32'h0000_00AA);
      check("n3_sel0_err",  2, 32'(if3.err),  32'd0);

      // 3-channel scan: wrap on the 12th sample only
      drive(1'b1, 1'b1, 1'b1, 2'd0, D0);
      for (int k = 0; k < 13; k++) begin
         drive(1'b0, 1'b1, 1'b1, 2'd3, D0);
         check("n3_scan_dout", k, 32'(if3.dout), 32'(byte_of(D0, (k / 4) % 3)));
         check("n3_scan_wrap", k, 32'(if3.wrap), 32'(k == 11));
         check("n3_scan_err",  k, 32'(if3.err),  32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
